status_flags_unit: RTL
======================

// Module: status_flags_unit
// PURPOSE
//  Produces and holds the processor status flags (Z, N, C, V) that the branch-condition logic consumes.
//  Derives the flags from the ALU operands and result, latches them on flags_write, and presents them as registered outputs.
//  Includes a small LIFO that saves and restores flags across CALL/RET and interrupt entry/exit.
//  Sits between the ALU and the jump-condition evaluator in the datapath.
// PARAMETERS
//  WIDTH        8  datapath width of ALU operands/result
//  STACK_DEPTH  4  flag-save LIFO entries (>=2); 4 bits {Z,N,C,V} per entry
// PORTS
//  clk          in   1            system clock, rising edge
//  reset        in   1            asynchronous, active-high reset
//  alu_a        in   WIDTH        ALU operand A
//  alu_b        in   WIDTH        ALU operand B (pre-inversion)
//  alu_result   in   WIDTH        ALU result this cycle
//  alu_arith    in   1            1: ADD/SUB/CMP (updates C,V); 0: logic op (clears C,V)
//  alu_sub      in   1            1: subtract/compare, 0: add (valid when alu_arith=1)
//  flags_write  in   1            latch computed flags at next edge
//  flags_push   in   1            save current stored flags to LIFO
//  flags_pop    in   1            restore stored flags from LIFO top
//  flag_z/n/c/v out  1 each       registered stored flags
//  stack_count  out  clog2(D+1)   LIFO occupancy
//  stack_full   out  1            count == STACK_DEPTH
//  stack_empty  out  1            count == 0
//  stack_err    out  1            sticky: push-on-full or pop-on-empty occurred
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-high.
//  Reset values: all flags 0, stack_count 0, stack_empty 1, stack_full 0, stack_err 0; LIFO contents are don't-care.
//  Flag computation (combinational, from inputs):
//   Z = (alu_result == 0); N = alu_result[WIDTH-1].
//   Arith: sum = {1'b0,alu_a} + {1'b0, alu_sub ? ~alu_b : alu_b} + alu_sub; C = sum[WIDTH].
//   SUB convention: C=1 means no borrow (a >= b unsigned).
//   V add: a[msb]==b[msb] && r[msb]!=a[msb]; V sub: a[msb]!=b[msb] && r[msb]!=a[msb].
//   Logic op (alu_arith=0): C=0, V=0; Z and N are still computed from alu_result.
//  Latency: flags written at edge k are visible on flag_* after edge k; no combinational input->output path.
//  Same-cycle bypass is done by the consumer, not here.
//  Push: LIFO[count] <= stored flags (value before any same-cycle update); count+1.
//  Pop: stored flags <= LIFO[count-1]; count-1.
//  Priority per cycle:
//   1) push && pop both high: LIFO untouched, treated as no stack op; flags_write still honoured.
//   2) pop (valid): restore wins; flags_write in the same cycle is ignored.
//   3) push (valid) + flags_write: old flags pushed, new computed flags latched.
//   4) flags_write alone: latch computed flags.
//   5) none: hold.
//  Boundaries:
//   push when stack_full: no write, count holds, stack_err<=1; flags_write is still honoured.
//   pop when stack_empty: no restore, count holds, stack_err<=1; flags_write is honoured.
//  stack_err is cleared only by reset.
//  full/empty/count are registered and consistent with each other every cycle.
//  Reset asserted mid-operation clears state immediately; the first edge after deassertion behaves as a normal cycle.
// TESTING
//  1. ADD a=0x7F b=0x01 r=0x80, flags_write -> next cycle Z=0 N=1 C=0 V=1.
//  2. SUB a=0x05 b=0x05 r=0x00 -> Z=1 N=0 C=1 V=0; SUB a=0x03 b=0x05 r=0xFE -> Z=0 N=1 C=0 V=0.
//  3. Logic op r=0x00 with prior C=V=1 -> Z=1 C=0 V=0.
//  4. Set flags 4'b1000, push; ADD giving 0x80 with flags_write; pop -> flags back to Z=1 N=C=V=0, count 0.
//  5. Five pushes with depth 4 -> count=4, stack_full=1, stack_err=1; four pops -> empty.
//     Fifth pop -> err stays 1, flags unchanged.
//  6. Pop + flags_write same cycle -> restored value wins.
//     push+pop same cycle -> count unchanged.
//     Reset asserted mid-sequence -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/status_flags_unit.sv
// Status flag generator and holder (Z, N, C, V) with a small save/restore LIFO
// used across CALL/RET and interrupt entry/exit.
module status_flags_unit #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned CNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_arith,
  input  logic             alu_sub,
  input  logic             flags_write,
  input  logic             flags_push,
  input  logic             flags_pop,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [CNT_W-1:0] stack_count,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned MSB   = WIDTH - 1;

  // Stored flags packed as {Z, N, C, V}
  logic [3:0]       flags_q;
  logic [3:0]       lifo [STACK_DEPTH];

  logic [WIDTH-1:0] b_eff_c;
  logic [SUM_W-1:0] sum_c;
  logic [3:0]       new_flags_c;
  logic             push_ok_c;
  logic             pop_ok_c;
  logic             err_set_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic [IDX_W-1:0] push_idx_c;
  logic [IDX_W-1:0] pop_idx_c;

  // Flag derivation from the ALU operands and result
  always_comb begin
    b_eff_c        = alu_sub ? ~alu_b : alu_b;
    sum_c          = {1'b0, alu_a} + {1'b0, b_eff_c} + SUM_W'(alu_sub);
    new_flags_c    = '0;
    new_flags_c[3] = (alu_result == '0);
    new_flags_c[2] = alu_result[MSB];
    if (alu_arith) begin
      new_flags_c[1] = sum_c[WIDTH];
      if (alu_sub) begin
        new_flags_c[0] = (alu_a[MSB] != alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
      end else begin
        new_flags_c[0] = (alu_a[MSB] == alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
      end
    end
  end

  // Stack operation qualification; simultaneous push and pop cancel out
  always_comb begin
    push_ok_c   = flags_push && !flags_pop && !stack_full;
    pop_ok_c    = flags_pop && !flags_push && !stack_empty;
    err_set_c   = (flags_push && !flags_pop && stack_full) ||
                  (flags_pop && !flags_push && stack_empty);
    push_idx_c  = IDX_W'(stack_count);
    pop_idx_c   = IDX_W'(stack_count - CNT_W'(1));
    count_nxt_c = stack_count;
    if (push_ok_c) begin
      count_nxt_c = stack_count + CNT_W'(1);
    end else if (pop_ok_c) begin
      count_nxt_c = stack_count - CNT_W'(1);
    end
  end

  // Flag register, occupancy and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= '0;
      stack_count <= '0;
      stack_full  <= 1'b0;
      stack_empty <= 1'b1;
      stack_err   <= 1'b0;
    end else begin
      if (pop_ok_c) begin
        flags_q <= lifo[pop_idx_c];
      end else if (flags_write) begin
        flags_q <= new_flags_c;
      end
      stack_count <= count_nxt_c;
      stack_full  <= (count_nxt_c == CNT_W'(STACK_DEPTH));
      stack_empty <= (count_nxt_c == '0);
      if (err_set_c) begin
        stack_err <= 1'b1;
      end
    end
  end

  // LIFO storage; contents are meaningless while unoccupied, so no reset
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      lifo[push_idx_c] <= flags_q;
    end
  end

  assign flag_z = flags_q[3];
  assign flag_n = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

endmodule
